// File: rtl/tx_pkg.sv
// tx_pkg: shared constants, scheduler state encoding and helpers for the frame scheduler.
//   PKT_W          width of one packet (8-bit header + 128-bit data)
//   FRAME_OVERHEAD preamble + SFD + header + CRC bits added around the payload
//   state_e        scheduler FSM states
//   frame_cnt()    frame-length counter preload (F-1) from the header length nibble
//   onehot_idx()   one-hot requester vector to its 2-bit index
package tx_pkg;
   localparam int PKT_W          = 136;
   localparam int PREAMBLE_BITS  = 16;
   localparam int SFD_BITS       = 8;
   localparam int HDR_BITS       = 8;
   localparam int CRC_BITS       = 8;
   localparam int FRAME_OVERHEAD = PREAMBLE_BITS + SFD_BITS + HDR_BITS + CRC_BITS;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_START      = 2'd1,
      S_WAIT_FRAME = 2'd2,
      S_GAP        = 2'd3
   } state_e;

   // F - 1 = FRAME_OVERHEAD + (len + 1) * 8 - 1, range 47..167
   function automatic logic [7:0] frame_cnt(input logic [3:0] len);
      return 8'(FRAME_OVERHEAD + 7) + {1'b0, len, 3'b000};
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction
endpackage

// File: rtl/tx_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin picker.
//   i_req        request vector
//   i_last_grant index of the previous winner; search starts one above it
//   o_winner     one-hot winner, zero when no request is present
module rr_arbiter4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_last_grant,
   output logic [3:0] o_winner
);
   logic [1:0] w_idx;

   // Scan from lowest to highest priority so the nearest requester after
   // last_grant overwrites any farther one.
   always_comb begin
      o_winner = '0;
      w_idx    = '0;
      for (int k = 4; k >= 1; k--) begin
         w_idx = i_last_grant + 2'(k);
         if (i_req[w_idx]) o_winner = 4'b0001 << w_idx;
      end
   end
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin frame scheduler feeding a serial transmitter.
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_sched_en     permits new grants; an in-flight frame/gap always completes
//   i_req          per-requester level request
//   i_req_packet   four packets, requester i at [136*i +: 136]
//   o_grant        one-cycle one-hot acknowledge (packet captured that cycle)
//   o_tx_start     one-cycle transmitter start pulse
//   o_tx_packet    packet held for the transmitter until the next grant
//   o_busy         high from the grant cycle through the last gap cycle
//   o_frame_done   one-cycle pulse on the last transmitter-active cycle
module tx_scheduler import tx_pkg::*; #(
   parameter int IFG = 12
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_sched_en,
   input  logic [3:0]         i_req,
   input  logic [4*PKT_W-1:0] i_req_packet,
   output logic [3:0]         o_grant,
   output logic               o_tx_start,
   output logic [PKT_W-1:0]   o_tx_packet,
   output logic               o_busy,
   output logic               o_frame_done
);
   localparam logic [7:0] GAP_CNT = (IFG == 0) ? 8'd0 : 8'(IFG - 1);

   state_e           r_state;
   logic [7:0]       r_cnt;
   logic [1:0]       r_last_grant;
   logic [3:0]       r_grant;
   logic             r_tx_start;
   logic [PKT_W-1:0] r_tx_packet;
   logic             r_busy;
   logic             r_frame_done;

   state_e     w_state_nx;
   logic [7:0] w_cnt_nx;
   logic [3:0] w_winner;
   logic [3:0] w_grant_nx;
   logic [1:0] w_win_idx;
   logic       w_tx_start_nx;
   logic       w_frame_done_nx;

   rr_arbiter4 u_arb (
      .i_req        (i_req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner)
   );

   assign w_win_idx = onehot_idx(w_winner);

   // Outputs are registered from next-state decisions, so each visible pulse
   // lags the internal state that produced it by one cycle.
   always_comb begin
      w_state_nx      = r_state;
      w_cnt_nx        = r_cnt;
      w_grant_nx      = '0;
      w_tx_start_nx   = 1'b0;
      w_frame_done_nx = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_sched_en && |i_req) begin
               w_grant_nx = w_winner;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            w_tx_start_nx = 1'b1;
            w_cnt_nx      = frame_cnt(r_tx_packet[131:128]);
            w_state_nx    = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (r_cnt == 8'd0) begin
               w_frame_done_nx = 1'b1;
               w_cnt_nx        = GAP_CNT;
               w_state_nx      = (IFG == 0) ? S_IDLE : S_GAP;
            end else begin
               w_cnt_nx = r_cnt - 8'd1;
            end
         end
         S_GAP: begin
            w_cnt_nx   = (r_cnt == 8'd0) ? r_cnt : r_cnt - 8'd1;
            w_state_nx = (r_cnt == 8'd0) ? S_IDLE : S_GAP;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_last_grant <= 2'd3;
         r_grant      <= '0;
         r_tx_start   <= 1'b0;
         r_tx_packet  <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_cnt        <= w_cnt_nx;
         r_grant      <= w_grant_nx;
         r_tx_start   <= w_tx_start_nx;
         r_frame_done <= w_frame_done_nx;
         // The first IDLE cycle after the gap is still the last visible gap cycle.
         r_busy       <= (r_state != S_IDLE) || (|w_grant_nx);
         if (|w_grant_nx) begin
            r_tx_packet  <= i_req_packet[w_win_idx*PKT_W +: PKT_W];
            r_last_grant <= w_win_idx;
         end
      end
   end

   assign o_grant      = r_grant;
   assign o_tx_start   = r_tx_start;
   assign o_tx_packet  = r_tx_packet;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed and random checks of two scheduler instances (IFG=12 and IFG=0) against a frame-timing model.
module tb_tx_scheduler;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sched_en = 1'b0;
   logic [3:0]   req = '0;
   logic [543:0] req_packet = '0;

   logic [3:0]   grant_o    [2];
   logic         tx_start_o [2];
   logic [135:0] tx_packet_o[2];
   logic         busy_o     [2];
   logic         done_o     [2];

   tx_scheduler #(.IFG(12)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sched_en(sched_en), .i_req(req), .i_req_packet(req_packet),
      .o_grant(grant_o[0]), .o_tx_start(tx_start_o[0]), .o_tx_packet(tx_packet_o[0]),
      .o_busy(busy_o[0]), .o_frame_done(done_o[0])
   );

   tx_scheduler #(.IFG(0)) dut_nogap (
      .i_clk(clk), .i_rst_n(rst_n), .i_sched_en(sched_en), .i_req(req), .i_req_packet(req_packet),
      .o_grant(grant_o[1]), .o_tx_start(tx_start_o[1]), .o_tx_packet(tx_packet_o[1]),
      .o_busy(busy_o[1]), .o_frame_done(done_o[1])
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: per instance, the cycle of the latest grant, its frame length,
   // and the first cycle a new grant may appear.
   int           m_last [2];
   int           m_g    [2];
   int           m_f    [2];
   int           m_free [2];
   logic [3:0]   m_gnt  [2];
   logic [135:0] m_pkt  [2];

   function automatic int ifg_of(input int d);
      return (d == 0) ? 12 : 0;
   endfunction

   function automatic int pick(input int last, input logic [3:0] r);
      for (int i = 1; i <= 4; i++) if (r[(last + i) % 4]) return (last + i) % 4;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      int w;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         m_gnt[d] = '0;
         if (!rst_n) begin
            m_last[d] = 3; m_g[d] = -1000; m_f[d] = 0; m_pkt[d] = '0; m_free[d] = cyc + 1;
         end else if (cyc >= m_free[d] && sched_en && req != 4'b0) begin
            w = pick(m_last[d], req);
            m_gnt[d][w] = 1'b1;
            m_last[d] = w;
            m_pkt[d] = req_packet[w*136 +: 136];
            m_f[d] = 40 + (int'(m_pkt[d][131:128]) + 1) * 8;
            m_g[d] = cyc;
            m_free[d] = cyc + 2 + m_f[d] + ifg_of(d);
         end
      end
   endtask

   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("grant%0d", d), 136'(grant_o[d]), 136'(m_gnt[d]));
         check($sformatf("tx_start%0d", d), 136'(tx_start_o[d]), 136'(cyc == m_g[d] + 1));
         check($sformatf("frame_done%0d", d), 136'(done_o[d]), 136'(cyc == m_g[d] + 1 + m_f[d]));
         check($sformatf("busy%0d", d), 136'(busy_o[d]),
               136'(cyc >= m_g[d] && cyc <= m_g[d] + 1 + m_f[d] + ifg_of(d)));
         check($sformatf("tx_packet%0d", d), tx_packet_o[d], m_pkt[d]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic wait_grant(input string tag, output int at);
      at = -1;
      for (int i = 0; i < 500; i++) begin
         step();
         if (grant_o[0] != 4'b0) begin
            at = cyc;
            break;
         end
      end
      check({tag, "_grant_seen"}, 136'(at >= 0), 136'(1));
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 400 && (busy_o[0] || busy_o[1]); i++) step();
      check("drain_idle", 136'(busy_o[0] || busy_o[1]), 136'(0));
   endtask

   task automatic set_pkt(input int i, input logic [7:0] hdr);
      req_packet[i*136 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_packet[i*136+128 +: 8] = hdr;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n, n2, done_at, bc;
      for (int i = 0; i < 17; i++) req_packet[i*32 +: 32] = $urandom();

      // Reset state
      step();
      step();
      check("rst_grant", 136'(grant_o[0]), 136'(0));
      check("rst_busy", 136'(busy_o[0]), 136'(0));
      check("rst_pkt", tx_packet_o[0], 136'(0));
      rst_n = 1'b1;
      sched_en = 1'b1;

      // Single requester, header 0x00: F=48, busy 62 cycles
      set_pkt(0, 8'h00);
      req = 4'b0001;
      wait_grant("t030", n);
      req = '0;
      check("t030_grant", 136'(grant_o[0]), 136'(4'b0001));
      bc = 1;
      done_at = -1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (done_o[0]) done_at = cyc;
         if (!busy_o[0]) break;
         bc++;
      end
      check("t030_done_ofs", 136'(done_at - n), 136'(49));
      check("t030_busy_len", 136'(bc), 136'(62));
      drain();

      // Scheduling disabled holds off a pending request
      sched_en = 1'b0;
      req = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         step();
         check("t033_blocked", 136'({grant_o[0], busy_o[0]}), 136'(0));
      end
      sched_en = 1'b1;
      step();
      check("t033_grant", 136'(grant_o[0]), 136'(4'b0010));
      req = '0;
      drain();

      // Longest frame, header 0x0F: F=168
      set_pkt(2, 8'h0F);
      req = 4'b0100;
      wait_grant("t032", n);
      req = '0;
      done_at = -1;
      for (int i = 0; i < 200 && done_at < 0; i++) begin
         step();
         if (done_o[0]) done_at = cyc;
      end
      check("t032_done_ofs", 136'(done_at - n), 136'(169));
      drain();

      // All four requesting: round-robin order 0,1,2,3,0 from reset
      do_reset();
      for (int i = 0; i < 4; i++) set_pkt(i, 8'h00);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant("t031", n);
         check($sformatf("t031_order%0d", k), 136'(grant_o[0]), 136'(4'b0001 << (k % 4)));
      end
      req = '0;
      drain();

      // Reset inside WAIT_FRAME abandons the frame
      set_pkt(0, 8'h03);
      req = 4'b0001;
      wait_grant("t034", n);
      req = '0;
      while (cyc < n + 31) step();
      rst_n = 1'b0;
      step();
      check("t034_rst_out", 136'({grant_o[0], tx_start_o[0], busy_o[0], done_o[0]}), 136'(0));
      check("t034_rst_pkt", tx_packet_o[0], 136'(0));
      rst_n = 1'b1;
      req = 4'b1001;
      wait_grant("t034b", n);
      check("t034_post_grant", 136'(grant_o[0]), 136'(4'b0001));
      req = '0;
      drain();

      // IFG=0 instance: back-to-back frames at N+F+2
      do_reset();
      set_pkt(0, 8'h00);
      req = 4'b0001;
      n = -1;
      n2 = -1;
      for (int i = 0; i < 300 && n2 < 0; i++) begin
         step();
         if (grant_o[1] != 4'b0) begin
            if (n < 0) n = cyc;
            else n2 = cyc;
         end
         if (n >= 0 && n2 < 0) check("t035_busy", 136'(busy_o[1]), 136'(1));
      end
      check("t035_spacing", 136'(n2 - n), 136'(50));
      req = '0;
      drain();

      // Random traffic, occasional disable and reset
      for (int i = 0; i < 6000; i++) begin
         req = 4'($urandom());
         sched_en = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 699) != 0);
         if ($urandom_range(0, 3) == 0) set_pkt($urandom_range(0, 3), 8'($urandom()));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
